// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud-rate helpers for the RX and TX sides
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction
   function automatic int clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
      return r;
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter that parks at zero and flags it
module uart_baud_tick #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign zero = cnt == '0;
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 receiver with one-byte valid/ready buffer, framing and overrun pulses
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 80000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       frame_err,
   output logic       overrun
);
   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W = clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   uart_state_t state;
   logic rx_m, rxs, zero, load, deliver;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic [CNT_W-1:0] load_val;
   always_ff @(posedge clk)
      if (reset) {rx_m, rxs} <= 2'b11;
      else {rx_m, rxs} <= {rx, rx_m};
   // every sample point in START/DATA reloads a full bit so STOP lands mid-bit too
   assign load = (state == IDLE && !rxs) || (state == START && zero && !rxs) || (state == DATA && zero);
   assign load_val = state == IDLE ? HALF_LOAD : FULL_LOAD;
   uart_baud_tick #(.W(CNT_W)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .load_val(load_val),
      .zero    (zero)
   );
   always_ff @(posedge clk)
      if (reset) begin
         state     <= IDLE;
         bit_idx   <= '0;
         shreg     <= '0;
         deliver   <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         deliver   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         case (state)
            IDLE:  if (!rxs) state <= START;
            START: if (zero) begin
               state   <= rxs ? IDLE : DATA;
               bit_idx <= '0;
            end
            DATA:  if (zero) begin
               shreg   <= {rxs, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == 3'd7) state <= STOP;
            end
            STOP:  if (zero) begin
               state     <= rxs ? IDLE : BREAK;
               deliver   <= rxs;
               frame_err <= !rxs;
            end
            BREAK: if (rxs) state <= IDLE;
            default: state <= IDLE;
         endcase
         // a consumer accepting in the delivery cycle frees the buffer for the new byte
         if (deliver && (!rd_valid || rd_ready)) begin
            rd_data  <= shreg;
            rd_valid <= 1'b1;
         end else if (deliver) overrun <= 1'b1;
         else if (rd_valid && rd_ready) rd_valid <= 1'b0;
      end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed bit-banged frames, expected bytes scoreboarded against transfers
module tb_uart_rx_deframer;
   localparam int BIT = 694;
   logic clk = 1'b0, reset = 1'b1, rx = 1'b1, rd_ready = 1'b0;
   logic [7:0] rd_data;
   logic rd_valid, frame_err, overrun;
   int n_vec = 0, n_err = 0, fe_cnt = 0, ov_cnt = 0, xfer_cnt = 0, lat = 6597;
   logic [7:0] exp_q[$];

   uart_rx_deframer dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   initial begin : monitor
      logic pv, px;
      logic [7:0] pd;
      pv = 1'b0; px = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (reset) pv = 1'b0;
         else begin
            if (pv && !px && rd_valid) check("hold_data", int'(rd_data), int'(pd));
            if (rd_valid && rd_ready) begin
               xfer_cnt++;
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_xfer: got 0x%0h, expected no transfer", rd_data);
               end else check("xfer_data", int'(rd_data), int'(exp_q.pop_front()));
            end
            fe_cnt += int'(frame_err);
            ov_cnt += int'(overrun);
            pv = rd_valid; px = rd_valid && rd_ready; pd = rd_data;
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BIT) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(posedge clk);
         #1;
      end
      rx = stop;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(name, exp_q.size(), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int got, x0, o0;
      got = 0;
      idle(3);
      check("rst_valid", int'(rd_valid), 0);
      check("rst_data", int'(rd_data), 0);
      check("rst_ferr", int'(frame_err), 0);
      check("rst_ovr", int'(overrun), 0);
      reset = 1'b0;
      idle(5);
      // 0xAA on the wire as 0,01010101,1 with consumer always ready
      rd_ready = 1'b1;
      exp_q.push_back(8'hAA);
      fork
         send_frame(8'hAA, 1'b1);
         for (int n = 1; n <= 7000; n++) begin
            @(posedge clk);
            #1;
            if (rd_valid) begin
               got = n;
               break;
            end
         end
      join
      check("latency_window", int'(got >= 6590 && got <= 6605), 1);
      if (got >= 6590 && got <= 6605) lat = got;
      drain("drain_aa");
      check("aa_xfers", xfer_cnt, 1);
      check("aa_ferr", fe_cnt, 0);
      check("aa_ovr", ov_cnt, 0);
      // short low glitch aborts at the mid-start sample
      x0 = xfer_cnt;
      rx = 1'b0;
      idle(100);
      rx = 1'b1;
      idle(1000);
      check("glitch_ferr", fe_cnt, 0);
      check("glitch_xfers", xfer_cnt, x0);
      check("glitch_valid", int'(rd_valid), 0);
      // bad stop bit followed by a held-low line
      send_frame(8'h3C, 1'b0);
      idle(2000);
      check("ferr_once", fe_cnt, 1);
      rx = 1'b1;
      idle(1000);
      check("ferr_no_retrig", fe_cnt, 1);
      check("ferr_xfers", xfer_cnt, x0);
      check("ferr_valid", int'(rd_valid), 0);
      // back-to-back frames with consumer stalled
      rd_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(10);
      check("ovr_pulse", ov_cnt, 1);
      check("ovr_hold_data", int'(rd_data), 8'h11);
      check("ovr_valid", int'(rd_valid), 1);
      rd_ready = 1'b1;
      drain("drain_ovr");
      idle(5);
      check("ovr_valid_drop", int'(rd_valid), 0);
      check("ovr_xfers", xfer_cnt, x0 + 1);
      // ready exactly in the delivery cycle of the second byte
      rd_ready = 1'b0;
      o0 = ov_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      exp_q.push_back(8'h22);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (lat - 1) @(posedge clk);
            #1 rd_ready = 1'b1;
            @(posedge clk);
            #1 rd_ready = 1'b0;
         end
      join
      check("sim_no_ovr", ov_cnt, o0);
      check("sim_data", int'(rd_data), 8'h22);
      check("sim_valid", int'(rd_valid), 1);
      check("sim_pending", exp_q.size(), 1);
      rd_ready = 1'b1;
      drain("drain_sim");
      // reset in the middle of data bit 4
      x0 = xfer_cnt;
      fork
         send_frame(8'hF0, 1'b1);
         begin
            idle(BIT * 5 + BIT / 2);
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
            check("mid_rst_data", int'(rd_data), 0);
            check("mid_rst_valid", int'(rd_valid), 0);
            check("mid_rst_ferr", int'(frame_err), 0);
            check("mid_rst_ovr", int'(overrun), 0);
         end
      join
      idle(100);
      check("mid_rst_xfers", xfer_cnt, x0);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      drain("drain_a5");
      check("a5_xfers", xfer_cnt, x0 + 1);
      check("final_ferr", fe_cnt, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side UART deframer. Consumes the asynchronous serial line `uartPins_rx` driven by the board (or the bench bit-banger) and produces 8-bit bytes on a valid/ready interface for the UART I/O device register block.
- Frame format: 8N1, LSB first, idle-high line.
- Detects framing errors and overruns, and reports each as a one-cycle pulse.

Parameters:
- CLK_FREQ, 80000000, core clock in Hz (12.5 ns period).
- BAUD_RATE, 115200, line bit rate.
- CLKS_PER_BIT, round(CLK_FREQ/BAUD_RATE) = 694 at defaults; derived, not overridden.
- CNT_W, clog2(CLKS_PER_BIT), bit-counter width; derived.

Ports:
- clk  in  1  core clock; the only clock.
- reset  in  1  synchronous, active-high.
- rx  in  1  asynchronous serial input, idle 1.
- rd_data  out  8  received byte; stable while rd_valid=1.
- rd_valid  out  1  byte available.
- rd_ready  in  1  consumer accepts; transfer happens when rd_valid & rd_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: new byte dropped because buffer was full.

Behaviour:
- Interface, decided: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - rd_data=0x00, rd_valid=0, frame_err=0, overrun=0.
  - Synchroniser flops = 1; FSM=IDLE; counters=0.
- Synchroniser: 2 flops on rx. The FSM sees only the synchronised value `rxs`, 2 cycles late.
- Baud counter: loaded on each state entry and decremented each cycle. An event occurs at count 0.
- FSM states and transitions:
  - IDLE: when rxs=0, load CLKS_PER_BIT/2-1 (346) and go to START.
  - START: at count 0, if rxs=0 (valid start, mid-bit), load CLKS_PER_BIT-1, set bit index to 0, and go to DATA. If rxs=1 it was a glitch: return to IDLE with no outputs.
  - DATA: at each count 0, shift rxs into the shift register MSB (shift right, so LSB first) and reload the counter. After the 8th sample go to STOP.
  - STOP: at count 0, sample rxs.
    - If 1: deliver the byte and go to IDLE.
    - If 0: pulse frame_err for 1 cycle, discard the byte, and go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. This prevents a held-low line from retriggering.
- Delivery, on the cycle after the stop-bit sample:
  - If rd_valid=0: load rd_data and set rd_valid=1.
  - If rd_valid=1 and rd_ready=1 in the delivery cycle: the old byte transfers, the new byte is loaded, rd_valid stays 1, and there is no overrun.
  - If rd_valid=1 and rd_ready=0: keep the old byte, drop the new one, and pulse overrun for 1 cycle.
- rd_valid deasserts the cycle after a transfer. rd_data must not change while rd_valid=1 except in the simultaneous case above.
- Latency: rd_valid rises 9*694+346+2 sync+1 cycles ≈ 6595 cycles (±2) after the rx falling edge.
- Receiver is ready for the next start bit in IDLE immediately after the stop sample, i.e. half a stop bit early. This tolerates clock mismatch.
- Reset mid-frame: everything returns to reset values on the next edge. A partial byte is never delivered.
- rd_ready asserted with rd_valid=0 has no effect.

Decomposition:
- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, STOP, BREAK).
  - Function computing CLKS_PER_BIT from CLK_FREQ/BAUD_RATE with rounding.
  - clog2 helper.
  - Shared with the existing transmitter.
- One sub-module: `uart_baud_tick`, a loadable down-counter with a zero flag. It is reusable by the TX side.
- Synchroniser, FSM and output buffer stay in the top.

Test Plan:
- Bit-bang 10'b0010101011 (start, 0x55 pattern on the wire, stop) at 8681 ns/bit with rd_ready=1 -> exactly one transfer with rd_data=0xAA, frame_err=0, overrun=0, rd_valid rising ≈6595 cycles after the falling edge.
- rx low pulse of 100 cycles, then high -> START aborts at the mid-bit sample; no rd_valid, no frame_err; FSM back in IDLE.
- Frame 0x3C with stop bit driven 0, then line held low 2000 cycles, then high -> single frame_err pulse, no rd_valid, no second frame_err while low.
- Two back-to-back frames 0x11, 0x22 with rd_ready=0 -> rd_data=0x11 held, overrun pulses once at the 2nd delivery; raising rd_ready then transfers 0x11 only.
- rd_ready pulsed exactly on the delivery cycle of the 2nd byte (0x11 pending) -> 0x11 transfers, rd_data=0x22 with rd_valid=1, no overrun.
- reset asserted for 1 cycle during data bit 4 of a frame -> outputs at reset values next cycle, no byte delivered; a following frame 0xA5 is received correctly.
